// File: rtl/multi_timer.sv
// N-channel down-counting timer with one-shot/auto-reload modes, sticky expiry flags and irq.
// Optional shared prescaler enabled by defining MULTI_TIMER_PRESCALE_EN.
module multi_timer #(
    parameter int N_CH       = 4,
    parameter int WIDTH      = 32,
    parameter int PRESCALE_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [N_CH-1:0]         start,
    input  logic [N_CH-1:0]         stop,
    input  logic [N_CH-1:0]         periodic,
    input  logic [N_CH*WIDTH-1:0]   load_value,
    input  logic [N_CH-1:0]         expired_clr,
    output logic [N_CH-1:0]         done,
    output logic [N_CH-1:0]         busy,
    output logic [N_CH*WIDTH-1:0]   count,
    output logic [N_CH-1:0]         expired,
    output logic                    irq
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic tick;

`ifdef MULTI_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] pre_cnt;

    assign tick = (pre_cnt == prescale);

    // A prescale value lowered below the running count restarts the phase without a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt >= prescale) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end
`else
    logic unused_prescale;

    assign unused_prescale = ^prescale;
    assign tick            = 1'b1;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [0:0]       state_q;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] reload_q;
        logic [WIDTH-1:0] ld;
        logic             mode_q;
        logic             done_q;
        logic             exp_q;
        logic             expire;

        assign ld = load_value[i*WIDTH +: WIDTH];

        // Start and stop both pre-empt a terminal count in the same cycle.
        assign expire = (state_q == ST_RUN) && tick && (cnt_q == '0) && !start[i] && !stop[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                reload_q <= '0;
                mode_q   <= 1'b0;
                done_q   <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (start[i]) begin
                    cnt_q    <= ld;
                    reload_q <= ld;
                    mode_q   <= periodic[i];
                    state_q  <= ST_RUN;
                end else if (stop[i]) begin
                    state_q <= ST_IDLE;
                end else if (expire) begin
                    done_q <= 1'b1;
                    if (mode_q) begin
                        cnt_q <= reload_q;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end else if ((state_q == ST_RUN) && tick) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                exp_q <= 1'b0;
            end else if (expire) begin
                exp_q <= 1'b1;
            end else if (expired_clr[i]) begin
                exp_q <= 1'b0;
            end
        end

        assign count[i*WIDTH +: WIDTH] = cnt_q;
        assign busy[i]                 = (state_q == ST_RUN);
        assign done[i]                 = done_q;
        assign expired[i]              = exp_q;
    end

    assign irq = |expired;

endmodule

// File: tb/tb_multi_timer.sv
// Randomized and directed bench for multi_timer, checked every cycle against a
// ticks-since-load model of each channel.
module tb_multi_timer;

    localparam int N_CH       = 4;
    localparam int WIDTH      = 16;
    localparam int PRESCALE_W = 8;
`ifdef MULTI_TIMER_PRESCALE_EN
    localparam int PRE = 2;
`else
    localparam int PRE = 0;
`endif

    logic                  clk;
    logic                  rst;
    logic [PRESCALE_W-1:0] prescale;
    logic [N_CH-1:0]       start;
    logic [N_CH-1:0]       stop;
    logic [N_CH-1:0]       periodic;
    logic [N_CH*WIDTH-1:0] load_value;
    logic [N_CH-1:0]       expired_clr;
    logic [N_CH-1:0]       done;
    logic [N_CH-1:0]       busy;
    logic [N_CH*WIDTH-1:0] count;
    logic [N_CH-1:0]       expired;
    logic                  irq;

    int n_checks = 0;
    int n_fail   = 0;

    multi_timer #(.N_CH(N_CH), .WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk(clk), .rst(rst), .prescale(prescale), .start(start), .stop(stop),
        .periodic(periodic), .load_value(load_value), .expired_clr(expired_clr),
        .done(done), .busy(busy), .count(count), .expired(expired), .irq(irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Each running channel is described by its load L and the ticks elapsed since the
    // last (re)load; its visible count is L minus that, a frozen value otherwise.
    bit              m_run [N_CH];
    bit              m_per [N_CH];
    bit              m_done[N_CH];
    bit              m_exp [N_CH];
    longint unsigned m_L   [N_CH];
    longint unsigned m_k   [N_CH];
    longint unsigned m_hold[N_CH];
    longint unsigned edge_cnt;
    bit              m_tick;

    function automatic longint unsigned m_count(int i);
        return m_run[i] ? (m_L[i] - m_k[i]) : m_hold[i];
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            edge_cnt = 0;
            for (int i = 0; i < N_CH; i++) begin
                m_run[i] = 0; m_per[i] = 0; m_done[i] = 0; m_exp[i] = 0;
                m_L[i] = 0; m_k[i] = 0; m_hold[i] = 0;
            end
        end else begin
            edge_cnt++;
            m_tick = ((edge_cnt % longint'(PRE + 1)) == 0);
            for (int i = 0; i < N_CH; i++) begin
                m_done[i] = 0;
                if (start[i]) begin
                    m_run[i] = 1;
                    m_per[i] = periodic[i];
                    m_L[i]   = longint'(load_value[i*WIDTH +: WIDTH]);
                    m_k[i]   = 0;
                end else if (stop[i]) begin
                    if (m_run[i]) m_hold[i] = m_L[i] - m_k[i];
                    m_run[i] = 0;
                end else if (m_run[i] && m_tick) begin
                    if (m_k[i] == m_L[i]) begin
                        m_done[i] = 1;
                        if (m_per[i]) begin
                            m_k[i] = 0;
                        end else begin
                            m_run[i]  = 0;
                            m_hold[i] = 0;
                        end
                    end else begin
                        m_k[i]++;
                    end
                end
                if (m_done[i]) m_exp[i] = 1;
                else if (expired_clr[i]) m_exp[i] = 0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input int ch,
                         input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s ch%0d at %0t: got %0d expected %0d", name, ch, $time, act, exp);
        end
    endtask

    initial forever begin
        bit exp_irq;
        @(negedge clk);
        exp_irq = 0;
        for (int i = 0; i < N_CH; i++) begin
            check("done",    i, longint'(done[i]),    longint'(m_done[i]));
            check("busy",    i, longint'(busy[i]),    longint'(m_run[i]));
            check("count",   i, longint'(count[i*WIDTH +: WIDTH]), m_count(i));
            check("expired", i, longint'(expired[i]), longint'(m_exp[i]));
            exp_irq = exp_irq | m_exp[i];
        end
        check("irq", 0, longint'(irq), longint'(exp_irq));
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load(input int ch, input int val);
        load_value[ch*WIDTH +: WIDTH] = WIDTH'(val);
    endtask

    function automatic int dut_count(int ch);
        return int'(count[ch*WIDTH +: WIDTH]);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int done_at, nd, nb, last, bad_gap, found, win;

        rst = 1'b1; prescale = PRESCALE_W'(PRE);
        start = '0; stop = '0; periodic = '0; load_value = '0; expired_clr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_busy",  0, longint'(busy), 0);
        check("reset_count", 0, longint'(count), 0);
        check("reset_irq",   0, longint'(irq), 0);
        step();

        // One-shot on ch0
`ifdef MULTI_TIMER_PRESCALE_EN
        set_load(0, 2);
`else
        set_load(0, 5);
`endif
        periodic[0] = 1'b0; start[0] = 1'b1;
        step();
        start = '0;
        done_at = -1; nd = 0; nb = 0;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (done[0]) begin nd++; if (done_at < 0) done_at = j; end
            if (busy[0]) nb++;
            step();
        end
`ifdef MULTI_TIMER_PRESCALE_EN
        check("t6_done_window", 0, longint'(done_at >= 7 && done_at <= 11), 1);
        check("t6_busy_cycles", 0, longint'(nb), longint'(done_at));
`else
        check("t1_done_cycle",  0, longint'(done_at), 6);
        check("t1_busy_cycles", 0, longint'(nb), 6);
`endif
        check("t1_done_pulses", 0, longint'(nd), 1);
        check("t1_expired",     0, longint'(expired[0]), 1);
        check("t1_irq",         0, longint'(irq), 1);

        // Periodic on ch1, L=3
        set_load(1, 3); periodic[1] = 1'b1; start[1] = 1'b1;
        step();
        start = '0;
        nd = 0; last = -1; bad_gap = 0;
        for (int j = 0; j < 24 * (PRE + 1) + 2; j++) begin
            @(negedge clk);
            if (done[1]) begin
                if (last >= 0 && (j - last) != 4 * (PRE + 1)) bad_gap++;
                last = j; nd++;
            end
            step();
        end
        check("t2_periods",  1, longint'(nd >= 5), 1);
        check("t2_bad_gaps", 1, longint'(bad_gap), 0);
        stop[1] = 1'b1;
        step();
        stop = '0;
        nd = 0; nb = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            nd += int'(done[1]); nb += int'(busy[1]);
            step();
        end
        check("t2_done_after_stop", 1, longint'(nd), 0);
        check("t2_busy_after_stop", 1, longint'(nb), 0);

        // Restart on ch2 at terminal count, with a same-cycle stop
        set_load(2, 2); periodic[2] = 1'b1; start[2] = 1'b1;
        step();
        start = '0;
        found = 0;
        for (int j = 0; j < 20 && !found; j++) begin
            @(negedge clk);
            if (dut_count(2) == 0) found = 1;
            else step();
        end
        check("t3_reached_zero", 2, longint'(found), 1);
        set_load(2, 10); start[2] = 1'b1; stop[2] = 1'b1;
        step();
        start = '0; stop = '0;
        @(negedge clk);
        check("t3_count",  2, longint'(dut_count(2)), 10);
        check("t3_done",   2, longint'(done[2]), 0);
        check("t3_busy",   2, longint'(busy[2]), 1);
        step();

        // Sticky flag: expiry and clear in the same cycle, clear alone next cycle
        stop = '1; expired_clr = '1;
        step();
        stop = '0;
        set_load(3, 1); periodic[3] = 1'b0; start[3] = 1'b1;
        step();
        start = '0;
        found = 0;
        for (int j = 0; j < 30 && !found; j++) begin
            @(negedge clk);
            if (done[3]) found = 1;
            else step();
        end
        check("t4_expiry_seen",   3, longint'(found), 1);
        check("t4_set_beats_clr", 3, longint'(expired[3]), 1);
        step();
        @(negedge clk);
        check("t4_clr",     3, longint'(expired[3]), 0);
        check("t4_irq_low", 0, longint'(irq), 0);
        step();
        expired_clr = '0;

        // Asynchronous reset while all channels run
        for (int i = 0; i < N_CH; i++) set_load(i, 20);
        periodic = 4'b0101; start = '1;
        step();
        start = '0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("t5_busy",    0, longint'(busy), 0);
        check("t5_done",    0, longint'(done), 0);
        check("t5_count",   0, longint'(count), 0);
        check("t5_expired", 0, longint'(expired), 0);
        check("t5_irq",     0, longint'(irq), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        nd = 0; win = 0;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            nd += int'(|done); win += int'(|busy);
            step();
        end
        check("t5_no_done_after_release", 0, longint'(nd), 0);
        check("t5_no_busy_after_release", 0, longint'(win), 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N_CH; i++) begin
                start[i]       = ($urandom_range(0, 11) == 0);
                stop[i]        = ($urandom_range(0, 29) == 0);
                expired_clr[i] = ($urandom_range(0, 7) == 0);
                periodic[i]    = 1'($urandom_range(0, 1));
                set_load(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40))
                                                        : int'($urandom_range(0, 6)));
            end
            step();
        end
        start = '0; stop = '0; expired_clr = '0;
        repeat (5) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
